// File: rtl/mult_pipe_nxn_if.sv
// ---------------------------------------------------------------------------
// mult_pipe_nxn_if
//   Handshake bundle for the pipelined DW x DW multiplier.
//   Input side : in_valid / in_ready, in_signed, in_tag, x, y
//   Output side: out_valid / out_ready, out_tag, ret (low half), carry (high half)
//   master : the producer/consumer that drives operations and takes results
//   slave  : the multiplier itself
// ---------------------------------------------------------------------------
interface mult_pipe_nxn_if #(
    parameter int DW = 128,
    parameter int TW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic          in_signed;
    logic [TW-1:0] in_tag;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_tag;
    logic [DW-1:0] ret;
    logic [DW-1:0] carry;

    modport master (
        output in_valid, in_signed, in_tag, x, y, out_ready,
        input  in_ready, out_valid, out_tag, ret, carry
    );

    modport slave (
        input  in_valid, in_signed, in_tag, x, y, out_ready,
        output in_ready, out_valid, out_tag, ret, carry
    );
endinterface

// File: rtl/mult_pipe_nxn.sv
// ---------------------------------------------------------------------------
// mult_pipe_nxn
//   Fully pipelined DW x DW multiplier (signed or unsigned per operation)
//   with valid/ready flow control and an opaque tag carried alongside.
//   Operands are split into LW-bit limbs; all limb products plus two sign
//   correction terms are registered, then summed by a registered binary
//   adder tree. Result {carry, ret} is the full 2*DW-bit product.
//
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    mult_pipe_nxn_if.slave (in_valid/in_ready, in_signed, in_tag,
//            x, y, out_valid/out_ready, out_tag, ret, carry)
//
//   Latency from accepting edge to out_valid: 2 + clog2(N*N+2) cycles.
//   Pipe: input register, product register, clog2(N*N+2) tree levels,
//   output register. A stalled output freezes every stage.
// ---------------------------------------------------------------------------
module mult_pipe_nxn #(
    parameter int DW = 128,
    parameter int LW = 16,
    parameter int TW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_pipe_nxn_if.slave bus
);
    localparam int N  = DW / LW;
    localparam int T  = N * N + 2;
    localparam int D  = $clog2(T);
    localparam int NS = D + 3;          // input + leaf + D tree levels + output
    localparam int PW = 2 * DW;

    // Number of terms held at tree level lvl (level 0 = leaf products).
    function automatic int lvl_cnt(input int lvl);
        int c;
        c = T;
        for (int k = 0; k < lvl; k++) c = (c + 1) / 2;
        return c;
    endfunction

    genvar gi, gj;

    logic          w_stall;
    logic [DW-1:0] r_x;
    logic [DW-1:0] r_y;
    logic          r_sgn;
    logic [NS-1:0] r_vld;
    logic [TW-1:0] r_tag [NS];
    logic [DW-1:0] r_ret;
    logic [DW-1:0] r_carry;

    logic [2*LW-1:0] w_prod [N*N];
    logic [PW-1:0]   w_leaf [T];

    // The only hold condition: a presented result the consumer refuses.
    assign w_stall      = r_vld[NS-1] & ~bus.out_ready;
    assign bus.in_ready = ~w_stall;

    // Input stage: operands and mode are captured unconditionally when the
    // pipe moves; the valid bit decides whether anything downstream cares.
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_x   <= bus.x;
            r_y   <= bus.y;
            r_sgn <= bus.in_signed;
        end
    end

    // Valid and tag shift in lock-step with the data stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int k = 0; k < NS; k++) r_tag[k] <= '0;
        end else if (!w_stall) begin
            r_vld    <= {r_vld[NS-2:0], bus.in_valid};
            r_tag[0] <= bus.in_tag;
            for (int k = 1; k < NS; k++) r_tag[k] <= r_tag[k-1];
        end
    end

    // Limb products, each placed at its weight (i+j)*LW in a 2*DW field.
    for (gi = 0; gi < N; gi++) begin : g_row
        for (gj = 0; gj < N; gj++) begin : g_col
            assign w_prod[gi*N+gj] = {LW'(0), r_x[gi*LW +: LW]} * {LW'(0), r_y[gj*LW +: LW]};
            assign w_leaf[gi*N+gj] = {{(PW-2*LW){1'b0}}, w_prod[gi*N+gj]} << ((gi + gj) * LW);
        end
    end

    // Signed correction: the unsigned product of two's-complement operands
    // over-counts by 2^DW*y when x is negative (and vice versa); subtract
    // those modulo 2^(2*DW) by adding their negation.
    assign w_leaf[N*N]   = (r_sgn && r_x[DW-1]) ? -{r_y, {DW{1'b0}}} : '0;
    assign w_leaf[N*N+1] = (r_sgn && r_y[DW-1]) ? -{r_x, {DW{1'b0}}} : '0;

    // Registered adder tree. Level 0 registers the leaf terms; each later
    // level adds adjacent pairs of the previous level, an odd last term is
    // carried forward unchanged.
    for (gi = 0; gi <= D; gi++) begin : g_lvl
        localparam int CNT = lvl_cnt(gi);
        logic [PW-1:0] r_term [CNT];

        if (gi == 0) begin : g_leaf
            always_ff @(posedge clk) begin
                if (!w_stall) begin
                    for (int k = 0; k < CNT; k++) r_term[k] <= w_leaf[k];
                end
            end
        end else begin : g_node
            localparam int PCNT = lvl_cnt(gi - 1);
            logic [PW-1:0] w_sum [CNT];

            for (gj = 0; gj < CNT; gj++) begin : g_el
                if (2 * gj + 1 < PCNT) begin : g_add
                    assign w_sum[gj] = g_lvl[gi-1].r_term[2*gj] + g_lvl[gi-1].r_term[2*gj+1];
                end else begin : g_pass
                    assign w_sum[gj] = g_lvl[gi-1].r_term[2*gj];
                end
            end

            always_ff @(posedge clk) begin
                if (!w_stall) begin
                    for (int k = 0; k < CNT; k++) r_term[k] <= w_sum[k];
                end
            end
        end
    end

    // Output stage: reset to zero so the bus is clean after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ret   <= '0;
            r_carry <= '0;
        end else if (!w_stall) begin
            {r_carry, r_ret} <= g_lvl[D].r_term[0];
        end
    end

    assign bus.out_valid = r_vld[NS-1];
    assign bus.out_tag   = r_tag[NS-1];
    assign bus.ret       = r_ret;
    assign bus.carry     = r_carry;

endmodule

// File: tb/tb_mult_pipe_nxn.sv
// ---------------------------------------------------------------------------
// tb_mult_pipe_nxn
//   Self-checking bench for mult_pipe_nxn. Instance A: DW=128/LW=16 (LAT=9),
//   instance B: DW=32/LW=8 (LAT=7). Expected products come from plain
//   sign/zero-extended multiplication held in per-instance scoreboards.
// ---------------------------------------------------------------------------
module tb_mult_pipe_nxn;
    localparam int LAT_A = 9;
    localparam int LAT_B = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    mult_pipe_nxn_if #(.DW(128), .TW(4)) a_if ();
    mult_pipe_nxn_if #(.DW(32),  .TW(4)) b_if ();

    mult_pipe_nxn #(.DW(128), .LW(16), .TW(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    mult_pipe_nxn #(.DW(32),  .LW(8),  .TW(4)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

    task automatic check_eq(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] gold_a(input logic [127:0] a, input logic [127:0] b, input logic s);
        logic [255:0] ae, be;
        ae = s ? {{128{a[127]}}, a} : {128'd0, a};
        be = s ? {{128{b[127]}}, b} : {128'd0, b};
        return ae * be;
    endfunction

    function automatic logic [255:0] gold_b(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ae, be, p;
        ae = s ? {{32{a[31]}}, a} : {32'd0, a};
        be = s ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ae * be;
        return {192'd0, p};
    endfunction

    function automatic logic [127:0] rnd128();
        case ($urandom_range(0, 7))
            0:       return {128{1'b1}};
            1:       return {1'b1, 127'd0};
            2:       return 128'd0;
            default: return {$urandom, $urandom, $urandom, $urandom};
        endcase
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [255:0] prod;
        logic [3:0]   tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   a_ndel = 0;
    int   b_ndel = 0;

    logic         a_prev_stall = 1'b0;
    logic [127:0] a_prev_ret, a_prev_carry;
    logic [3:0]   a_prev_tag;

    // Scoreboard A: checks delivered results, stall stability and in_ready.
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            a_prev_stall = 1'b0;
        end else begin
            check_eq("a_in_ready", a_if.in_ready, !(a_if.out_valid && !a_if.out_ready));
            if (a_prev_stall) begin
                check_eq("a_hold_valid", a_if.out_valid, 1'b1);
                check_eq("a_hold_ret",   a_if.ret,   a_prev_ret);
                check_eq("a_hold_carry", a_if.carry, a_prev_carry);
                check_eq("a_hold_tag",   a_if.out_tag, a_prev_tag);
            end
            if (a_if.out_valid && a_if.out_ready) begin
                if (qa.size() == 0) begin
                    check_eq("a_unexpected_out", a_if.out_valid, 1'b0);
                end else begin
                    ea = qa.pop_front();
                    check_eq("a_product", {a_if.carry, a_if.ret}, ea.prod);
                    check_eq("a_tag", a_if.out_tag, ea.tag);
                    a_ndel++;
                end
            end else if (qa.size() == 0) begin
                check_eq("a_idle_valid", a_if.out_valid, 1'b0);
            end
            if (a_if.in_valid && a_if.in_ready) begin
                ea.prod = gold_a(a_if.x, a_if.y, a_if.in_signed);
                ea.tag  = a_if.in_tag;
                qa.push_back(ea);
            end
            a_prev_stall = a_if.out_valid && !a_if.out_ready;
            a_prev_ret   = a_if.ret;
            a_prev_carry = a_if.carry;
            a_prev_tag   = a_if.out_tag;
        end
    end

    // Scoreboard B.
    always @(negedge clk) begin
        if (!rst_n) begin
            qb.delete();
        end else begin
            if (b_if.out_valid && b_if.out_ready) begin
                if (qb.size() == 0) begin
                    check_eq("b_unexpected_out", b_if.out_valid, 1'b0);
                end else begin
                    eb = qb.pop_front();
                    check_eq("b_product", {b_if.carry, b_if.ret}, eb.prod);
                    check_eq("b_tag", b_if.out_tag, eb.tag);
                    b_ndel++;
                end
            end else if (qb.size() == 0) begin
                check_eq("b_idle_valid", b_if.out_valid, 1'b0);
            end
            if (b_if.in_valid && b_if.in_ready) begin
                eb.prod = gold_b(b_if.x, b_if.y, b_if.in_signed);
                eb.tag  = b_if.in_tag;
                qb.push_back(eb);
            end
        end
    end

    // Single op on A from an empty pipe: latency plus explicit result.
    task automatic run_a(input string nm, input logic [127:0] x, input logic [127:0] y,
                         input logic s, input logic [3:0] tag,
                         input logic [127:0] exp_carry, input logic [127:0] exp_ret);
        int n;
        a_if.x = x; a_if.y = y; a_if.in_signed = s; a_if.in_tag = tag;
        a_if.in_valid = 1'b1;
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        n = 0;
        while (!a_if.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({nm, "_latency"}, n, LAT_A);
        check_eq({nm, "_carry"}, a_if.carry, exp_carry);
        check_eq({nm, "_ret"}, a_if.ret, exp_ret);
        check_eq({nm, "_tag"}, a_if.out_tag, tag);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ones, top;
        int           sent, cyc, nstall, del0, seen, n;
        logic         acc, need_new;

        ones = '1;
        top  = {1'b1, 127'd0};

        a_if.in_valid = 0; a_if.in_signed = 0; a_if.in_tag = 0; a_if.x = 0; a_if.y = 0; a_if.out_ready = 1;
        b_if.in_valid = 0; b_if.in_signed = 0; b_if.in_tag = 0; b_if.x = 0; b_if.y = 0; b_if.out_ready = 1;

        // Traffic while reset is held.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            a_if.in_valid = 1'b1; a_if.x = rnd128(); a_if.y = rnd128(); a_if.in_tag = 4'(k);
        end
        @(negedge clk);
        check_eq("rst_out_valid", a_if.out_valid, 1'b0);
        check_eq("rst_ret",       a_if.ret, 128'd0);
        check_eq("rst_carry",     a_if.carry, 128'd0);
        check_eq("rst_out_tag",   a_if.out_tag, 4'd0);
        check_eq("rst_in_ready",  a_if.in_ready, 1'b1);
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < LAT_A + 3; k++) begin
            @(negedge clk);
            if (a_if.out_valid) seen++;
        end
        check_eq("post_rst_quiet", seen, 0);
        check_eq("post_rst_in_ready", a_if.in_ready, 1'b1);
        @(posedge clk); #1;

        // Directed corner products.
        run_a("umax", ones, ones, 1'b0, 4'd3, {ones[127:1], 1'b0}, 128'd1);
        run_a("s_m1_m1", ones, ones, 1'b1, 4'd5, 128'd0, 128'd1);
        run_a("s_m1_2", ones, 128'd2, 1'b1, 4'd9, ones, {ones[127:1], 1'b0});
        run_a("s_min_min", top, top, 1'b1, 4'd12, {2'b01, 126'd0}, 128'd0);

        // Streaming with a 5-cycle back-pressure window.
        sent = 0; cyc = 0; nstall = 0; need_new = 1'b1; del0 = a_ndel;
        while ((sent < 20 || qa.size() != 0) && cyc < 300) begin
            a_if.out_ready = !(cyc >= 12 && cyc < 17);
            if (sent < 20) begin
                if (need_new) begin
                    a_if.x = rnd128(); a_if.y = rnd128();
                    a_if.in_signed = 1'($urandom_range(0, 1));
                    a_if.in_tag = 4'(sent % 16);
                    need_new = 1'b0;
                end
                a_if.in_valid = 1'b1;
            end else begin
                a_if.in_valid = 1'b0;
            end
            @(negedge clk);
            acc = a_if.in_valid && a_if.in_ready;
            if (!a_if.in_ready) nstall++;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                need_new = 1'b1;
            end
            cyc++;
        end
        a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
        check_eq("stream_sent", sent, 20);
        check_eq("stream_drained", qa.size(), 0);
        check_eq("stream_delivered", a_ndel - del0, 20);
        check_eq("stream_stall_cycles", nstall, 5);

        // Reset with operations in flight: none may emerge afterwards.
        for (int k = 0; k < 5; k++) begin
            a_if.x = rnd128(); a_if.y = rnd128(); a_if.in_tag = 4'(k); a_if.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        a_if.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (a_if.out_valid) seen++;
        end
        check_eq("midop_rst_flushed", seen, 0);
        @(posedge clk); #1;
        run_a("after_rst", 128'd7, 128'd6, 1'b0, 4'd1, 128'd0, 128'd42);

        // Instance B: latency of a lone op, then 1000 random ops.
        b_if.x = 32'hFFFF_FFFF; b_if.y = 32'd3; b_if.in_signed = 1'b1; b_if.in_tag = 4'd6;
        b_if.in_valid = 1'b1;
        @(posedge clk); #1;
        b_if.in_valid = 1'b0;
        n = 0;
        while (!b_if.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("b_latency", n, LAT_B);
        check_eq("b_lone_product", {b_if.carry, b_if.ret}, 64'hFFFF_FFFF_FFFF_FFFD);
        @(posedge clk); #1;

        sent = 0; cyc = 0; del0 = b_ndel;
        while ((sent < 1000 || qb.size() != 0) && cyc < 20000) begin
            b_if.out_ready = ($urandom_range(0, 3) != 0);
            if (!b_if.in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                b_if.x = rnd32(); b_if.y = rnd32();
                b_if.in_signed = 1'($urandom_range(0, 1));
                b_if.in_tag = 4'(sent % 16);
                b_if.in_valid = 1'b1;
            end
            @(negedge clk);
            acc = b_if.in_valid && b_if.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                b_if.in_valid = 1'b0;
            end
            cyc++;
        end
        b_if.in_valid = 1'b0; b_if.out_ready = 1'b1;
        check_eq("b_sent", sent, 1000);
        check_eq("b_drained", qb.size(), 0);
        check_eq("b_delivered", b_ndel - del0, 1000);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_pipe_nxn.md
# mult_pipe_nxn

Parametrised, fully pipelined DW×DW multiplier with valid/ready flow control, tag passthrough and per-operation signed/unsigned mode. Each operand is split into LW-bit limbs. All limb products are formed in parallel, then summed by a registered binary adder tree. The block sits in the IDDMM datapath wherever a wide product feeds the Montgomery reduction loop, and accepts one operation per cycle when not back-pressured.

## Interface
- DW, 128, operand width; DW % LW == 0; N = DW/LW ≥ 2
- LW, 16, limb width (one hardware multiplier per limb pair)
- TW, 4, width of the opaque tag carried alongside each operation
- clk  in  1  clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept this cycle
- in_signed  in  1  1: two's-complement operands; 0: unsigned
- in_tag  in  TW  tag returned with the result
- x  in  DW  multiplicand
- y  in  DW  multiplier
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts result
- out_tag  out  TW  tag of the presented result
- ret  out  DW  product bits [DW-1:0]
- carry  out  DW  product bits [2DW-1:DW]

## Operation
- Stage P: register all N·N products x_i·y_j (2·LW bits each) plus two correction terms.
- Correction terms exist only when in_signed=1:
  - cx = x[DW-1] ? (y << DW) : 0
  - cy = y[DW-1] ? (x << DW) : 0
  - Both are subtracted modulo 2^(2DW), entered into the tree as their 2's complement.
  - When in_signed=0 both terms are 0.
- Each product x_i·y_j is shifted by (i+j)·LW and zero-extended to 2DW bits.
- Tree: T = N·N+2 terms, reduced pairwise per stage over D = clog2(T) registered stages. An odd term at any level passes through registered.
- All tree arithmetic is 2DW bits wide and modulo 2^(2DW); no overflow flag.
- Output stage: {carry, ret} = final sum; out_tag = tag of that operation.
- Per-stage valid bit and tag shift register run in lock-step with the data. Bubbles propagate as valid=0.
- Operation order is preserved; there is no reordering and no drop.

## Timing
- Latency LAT = 2 + clog2(N·N+2) cycles from the accepting edge to out_valid; defaults give 66 terms, D=7, LAT=9.
- Accept occurs on a rising edge with in_valid & in_ready; deliver occurs on a rising edge with out_valid & out_ready.
- stall = out_valid & ~out_ready. in_ready = ~stall (combinational).
- While stall=1, every pipeline register (data, valid, tag) holds. ret/carry/out_tag/out_valid stay stable until the deliver edge.
- No skid buffer: a stall freezes the whole pipe, including bubbles.
- Throughput is 1 op/cycle with out_ready held high.
- in_signed is sampled at accept only.
- Reset (async assert, synchronous-safe deassert handled upstream):
  - out_valid=0, all stage valids=0, ret=0, carry=0, out_tag=0; in_ready=1 after reset.
  - Internal data/tag registers need not be reset.
- Reset mid-operation: all in-flight operations are discarded and none emerge after release.
- Simultaneous accept and deliver while stalled is impossible because in_ready=0. A deliver edge with in_valid=1 accepts a new op on the same edge.

## Test plan
- Reset: hold rst_n=0 during traffic, then release -> out_valid=0, ret=carry=0, in_ready=1; no output for LAT cycles; in-flight ops never appear.
- Unsigned max: x=y=2^128-1, in_signed=0, tag=3 -> after 9 cycles carry=0xFFFF…FFFE, ret=0x0000…0001, out_tag=3.
- Signed sign cases:
  - x=y=all-ones, in_signed=1 -> carry=0, ret=1.
  - x=all-ones, y=2, in_signed=1 -> carry=all-ones, ret=0xFFFF…FFFE.
  - x=2^127, y=2^127, in_signed=1 -> carry=2^126, ret=0.
- Streaming: 20 back-to-back random ops, tags 0..15 wrapping, mixed in_signed, out_ready=1 -> 1 result/cycle after 9-cycle latency, matching a 256-bit golden model, tags in order.
- Back-pressure: during streaming, drop out_ready for 5 cycles -> in_ready=0 the same cycles; ret/carry/out_tag/out_valid stable; zero loss or duplication after resume.
- Parameter sweep: DW=64/LW=16 (N=4, LAT=7) and DW=32/LW=8 (N=4, LAT=7), 1000 random ops each -> exact match, latency as computed.
